// File: rtl/imem_prog_loader.sv
// imem_prog_loader
//   Run-time loadable instruction memory for the CPU fetch stage. A byte-wide
//   ready/valid loader stream is assembled MSB-first into INST_W-bit words and
//   written sequentially from address 0. Fetches are registered (one-cycle
//   latency) and return NOP_WORD for addresses at or beyond the loaded length.
//
//   State table
//     RUN  | fetches served, loader stalled (ld_ready=0)
//     LOAD | loader bytes accepted and assembled, fetches blocked
//     DONE | single-cycle ld_done pulse, then back to RUN
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   load_start               pulse: begin (or restart) a program load at addr 0
//   ld_valid/ld_data/ld_last loader byte stream, ld_last marks final byte
//   ld_ready                 loader byte accepted when high with ld_valid
//   ld_err                   sticky: program exceeded memory depth
//   ld_done                  one-cycle pulse when a load finishes
//   prog_len                 number of valid words stored (0 .. 2**ADDR_W)
//   fetch_req/fetch_addr     fetch request and word address
//   fetch_rdy                fetch accepted this cycle
//   inst/inst_vld            fetched word (held) and its update pulse
module imem_prog_loader #(
  parameter int                ADDR_W   = 8,
  parameter int                INST_W   = 16,
  parameter logic [INST_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_err,
  output logic              ld_done,
  output logic [ADDR_W:0]   prog_len,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_rdy,
  output logic [INST_W-1:0] inst,
  output logic              inst_vld
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = INST_W / 8;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [INST_W-1:0] mem [0:DEPTH-1];
  logic [INST_W-1:0] wbuf;
  logic [INST_W-1:0] next_buf;
  logic [INST_W-1:0] wr_word;
  logic [CNT_W-1:0]  byte_cnt;
  logic              enter_load;
  logic              accept;
  logic              full;
  logic              word_end;

  // Memory is full once prog_len reaches DEPTH (only the MSB is set).
  assign full = prog_len[ADDR_W];

  // A load_start cycle restarts the load; any byte presented with it is dropped.
  assign enter_load = load_start && (state == RUN || state == LOAD);
  assign accept     = ld_valid && ld_ready && !load_start;
  assign word_end   = accept && !full &&
                      (byte_cnt == CNT_W'(NB - 1) || ld_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_ready  = 1'b0;
    ld_done   = 1'b0;
    fetch_rdy = 1'b0;
    case (state)
      RUN: begin
        fetch_rdy = 1'b1;
        if (load_start) state_nxt = LOAD;
      end
      LOAD: begin
        ld_ready = 1'b1;
        if (load_start)                   state_nxt = LOAD;
        else if (ld_valid && ld_last)     state_nxt = DONE;
      end
      DONE: begin
        ld_done   = 1'b1;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Word assembly: shift the new byte in, then left-justify a short final word
  // so the missing low bytes come out as zero.
  always_comb begin
    next_buf = (wbuf << 8) | INST_W'(ld_data);
    wr_word  = next_buf << (8 * (NB - 1 - int'(byte_cnt)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prog_len <= '0;
      byte_cnt <= '0;
      wbuf     <= '0;
      ld_err   <= 1'b0;
    end else if (enter_load) begin
      prog_len <= '0;
      byte_cnt <= '0;
      wbuf     <= '0;
      ld_err   <= 1'b0;
    end else if (accept) begin
      if (full) begin
        ld_err <= 1'b1;
      end else if (word_end) begin
        prog_len <= prog_len + (ADDR_W + 1)'(1);
        byte_cnt <= '0;
        wbuf     <= '0;
      end else begin
        wbuf     <= next_buf;
        byte_cnt <= byte_cnt + CNT_W'(1);
      end
    end
  end

  // The write address is the low bits of prog_len; the full check above keeps
  // it from wrapping back onto word 0.
  always_ff @(posedge clk) begin
    if (word_end) mem[prog_len[ADDR_W-1:0]] <= wr_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst     <= NOP_WORD;
      inst_vld <= 1'b0;
    end else begin
      inst_vld <= fetch_req && fetch_rdy;
      if (fetch_req && fetch_rdy) begin
        if ({1'b0, fetch_addr} < prog_len) inst <= mem[fetch_addr];
        else                               inst <= NOP_WORD;
      end
    end
  end

endmodule

// File: tb/tb_imem_prog_loader.sv
// Directed bench: one stimulus set drives a default-sized instance and a
// 4-word instance side by side; each instance is checked against its own
// hand-computed expectations.
module tb_imem_prog_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_start = 1'b0;
  logic       ld_valid = 1'b0;
  logic [7:0] ld_data = 8'h00;
  logic       ld_last = 1'b0;
  logic       fetch_req = 1'b0;
  logic [7:0] fetch_addr = 8'h00;

  logic        ld_ready, ld_err, ld_done, fetch_rdy, inst_vld;
  logic [8:0]  prog_len;
  logic [15:0] inst;

  logic        s_ld_ready, s_ld_err, s_ld_done, s_fetch_rdy, s_inst_vld;
  logic [2:0]  s_prog_len;
  logic [15:0] s_inst;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  imem_prog_loader u_dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .ld_err     (ld_err),
    .ld_done    (ld_done),
    .prog_len   (prog_len),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_rdy  (fetch_rdy),
    .inst       (inst),
    .inst_vld   (inst_vld)
  );

  imem_prog_loader #(.ADDR_W(2)) u_dut_small (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (s_ld_ready),
    .ld_err     (s_ld_err),
    .ld_done    (s_ld_done),
    .prog_len   (s_prog_len),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr[1:0]),
    .fetch_rdy  (s_fetch_rdy),
    .inst       (s_inst),
    .inst_vld   (s_inst_vld)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_load();
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // Presents one byte for one cycle; caller is already in LOAD.
  task automatic send_byte(input logic [7:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    @(negedge clk);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // Single fetch; on return the result of that fetch is visible.
  task automatic fetch(input logic [7:0] a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    @(negedge clk);
    fetch_req  = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_prog_len", 32'(prog_len), 0);
    check("rst_ld_ready", 32'(ld_ready), 0);
    check("rst_ld_err",   32'(ld_err),   0);
    check("rst_ld_done",  32'(ld_done),  0);
    check("rst_inst_vld", 32'(inst_vld), 0);
    check("rst_fetch_rdy", 32'(fetch_rdy), 1);

    fetch(8'h05);
    check("empty_vld",  32'(inst_vld), 1);
    check("empty_inst", 32'(inst),     32'h0000);
    @(negedge clk);
    check("vld_pulse", 32'(inst_vld), 0);

    // Two-word program
    start_load();
    check("load_ready", 32'(ld_ready),  1);
    check("load_frdy",  32'(fetch_rdy), 0);
    send_byte(8'h3A, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h3B, 1'b0);
    send_byte(8'h03, 1'b1);
    check("done_pulse", 32'(ld_done),  1);
    check("done_ready", 32'(ld_ready), 0);
    check("len2",       32'(prog_len), 2);
    @(negedge clk);
    check("done_clear", 32'(ld_done), 0);
    fetch(8'h00); check("w0", 32'(inst), 32'h3A02);
    fetch(8'h01); check("w1", 32'(inst), 32'h3B03);
    fetch(8'h02); check("w2_nop", 32'(inst), 32'h0000);
    check("w2_vld", 32'(inst_vld), 1);

    // Odd-length program: final word zero-padded
    start_load();
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b1);
    @(negedge clk);
    check("odd_len", 32'(prog_len), 2);
    fetch(8'h00); check("odd_w0", 32'(inst), 32'h1234);
    fetch(8'h01); check("odd_w1", 32'(inst), 32'h5600);

    // Back-to-back fetches 0,1,0,1
    begin
      logic [15:0] exp_w [4];
      exp_w[0] = 16'h1234; exp_w[1] = 16'h5600;
      exp_w[2] = 16'h1234; exp_w[3] = 16'h5600;
      fetch_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
        fetch_addr = 8'(i % 2);
        @(negedge clk);
        check($sformatf("b2b_vld%0d", i),  32'(inst_vld), 1);
        check($sformatf("b2b_inst%0d", i), 32'(inst),     32'(exp_w[i]));
      end
      fetch_req = 1'b0;
      @(negedge clk);
      check("b2b_end", 32'(inst_vld), 0);
    end

    // 10 bytes: overflows the 4-word instance, fits the large one
    start_load();
    for (int i = 1; i <= 10; i++) send_byte(8'(i), i == 10);
    check("ovf_done",     32'(s_ld_done),  1);
    check("ovf_len_s",    32'(s_prog_len), 4);
    check("ovf_err_s",    32'(s_ld_err),   1);
    check("ovf_len",      32'(prog_len),   5);
    check("ovf_err",      32'(ld_err),     0);
    @(negedge clk);
    fetch(8'h00); check("ovf_w0_s", 32'(s_inst), 32'h0102);
    fetch(8'h03); check("ovf_w3_s", 32'(s_inst), 32'h0708);
    fetch(8'h04); check("ovf_w4",   32'(inst),   32'h090A);

    // Restart mid-load; fetch requests ignored while loading
    start_load();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    fetch_req = 1'b1; fetch_addr = 8'h00;
    send_byte(8'h33, 1'b0);
    fetch_req = 1'b0;
    check("load_no_fetch", 32'(inst_vld), 0);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    check("restart_len", 32'(prog_len), 0);
    check("restart_err_s", 32'(s_ld_err), 0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b1);
    @(negedge clk);
    check("restart_len1",   32'(prog_len),   1);
    check("restart_len1_s", 32'(s_prog_len), 1);
    fetch(8'h00); check("restart_w0",  32'(inst), 32'hAABB);
    fetch(8'h01); check("restart_w1",  32'(inst), 32'h0000);

    // Async reset during load
    start_load();
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    check("pre_rst_len", 32'(prog_len), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_ready", 32'(ld_ready), 0);
    check("arst_len",   32'(prog_len), 0);
    @(negedge clk);
    rst = 1'b0;
    fetch(8'h00);
    check("arst_vld",  32'(inst_vld), 1);
    check("arst_inst", 32'(inst),     32'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
